// File: rtl/activation_argmax_if.sv
// Handshake bus for activation_argmax: vector/threshold in, classified digit out.
interface activation_argmax_if #(
  parameter int unsigned number_neuron = 10,
  parameter int unsigned resolution    = 8
);
  localparam int unsigned IDX_W = $clog2(number_neuron);

  logic                                in_valid;
  logic                                in_ready;
  logic [resolution*number_neuron-1:0] activations;
  logic [resolution-1:0]               threshold;
  logic                                out_valid;
  logic                                out_ready;
  logic [IDX_W-1:0]                    digit;
  logic [resolution-1:0]               max_value;
  logic [resolution:0]                 margin;
  logic                                low_confidence;
  logic                                busy;

  modport slave (
    input  in_valid, activations, threshold, out_ready,
    output in_ready, out_valid, digit, max_value, margin, low_confidence, busy
  );

  modport master (
    output in_valid, activations, threshold, out_ready,
    input  in_ready, out_valid, digit, max_value, margin, low_confidence, busy
  );
endinterface

// File: rtl/activation_argmax.sv
// Sequential argmax over the output-layer activation vector: one lane per clock,
// reports winning index, its value, margin over runner-up and a low-confidence flag.
module activation_argmax #(
  parameter int unsigned number_neuron = 10,
  parameter int unsigned resolution    = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  activation_argmax_if.slave  bus
);
  localparam int unsigned IDX_W = $clog2(number_neuron);
  localparam int unsigned VEC_W = resolution * number_neuron;
  localparam int unsigned MAR_W = resolution + 1;

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t                        state_q;
  logic [VEC_W-1:0]              vec_q;
  logic [resolution-1:0]         thr_q;
  logic signed [resolution-1:0]  best_q;
  logic signed [resolution-1:0]  second_q;
  logic [IDX_W-1:0]              best_idx_q;
  logic [IDX_W-1:0]              k_q;
  logic [IDX_W-1:0]              digit_q;
  logic [resolution-1:0]         max_q;
  logic [MAR_W-1:0]              margin_q;
  logic                          low_q;
  logic                          out_valid_q;

  logic signed [resolution-1:0]  lane_c;
  logic signed [resolution-1:0]  best_c;
  logic signed [resolution-1:0]  second_c;
  logic [IDX_W-1:0]              best_idx_c;
  logic signed [MAR_W-1:0]       diff_c;
  logic                          low_c;
  logic                          last_c;

  localparam logic signed [resolution-1:0] MIN_VAL = {1'b1, {(resolution-1){1'b0}}};

  // Compare the current lane against the running best/runner-up; strict > keeps the lowest index on ties.
  always_comb begin
    lane_c     = $signed(vec_q[int'(k_q)*resolution +: resolution]);
    best_c     = best_q;
    second_c   = second_q;
    best_idx_c = best_idx_q;
    if (lane_c > best_q) begin
      second_c   = best_q;
      best_c     = lane_c;
      best_idx_c = k_q;
    end else if (lane_c > second_q) begin
      second_c = lane_c;
    end
    diff_c = MAR_W'(best_c) - MAR_W'(second_c);
    low_c  = $unsigned(diff_c) < {1'b0, thr_q};
    last_c = (k_q == IDX_W'(number_neuron - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      vec_q       <= '0;
      thr_q       <= '0;
      best_q      <= '0;
      second_q    <= '0;
      best_idx_q  <= '0;
      k_q         <= '0;
      digit_q     <= '0;
      max_q       <= '0;
      margin_q    <= '0;
      low_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            vec_q      <= bus.activations;
            thr_q      <= bus.threshold;
            best_q     <= $signed(bus.activations[resolution-1:0]);
            second_q   <= MIN_VAL;
            best_idx_q <= '0;
            k_q        <= IDX_W'(1);
            state_q    <= SCAN;
          end
        end
        SCAN: begin
          best_q     <= best_c;
          second_q   <= second_c;
          best_idx_q <= best_idx_c;
          if (last_c) begin
            k_q         <= '0;
            digit_q     <= best_idx_c;
            max_q       <= best_c;
            margin_q    <= diff_c;
            low_q       <= low_c;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            k_q <= k_q + IDX_W'(1);
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready       = (state_q == IDLE);
  assign bus.busy           = (state_q == SCAN) || (state_q == DONE);
  assign bus.out_valid      = out_valid_q;
  assign bus.digit          = digit_q;
  assign bus.max_value      = max_q;
  assign bus.margin         = margin_q;
  assign bus.low_confidence = low_q;
endmodule

// File: tb/tb_activation_argmax.sv
// Scoreboard bench for activation_argmax: directed vectors, monitor checks results and latency.
module tb_activation_argmax;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  typedef struct {
    logic [3:0] digit;
    logic [7:0] maxv;
    logic [8:0] margin;
    logic       low;
    int         acc;
  } exp_t;

  exp_t q[$];
  logic prev_ov = 1'b0;

  activation_argmax_if #(.number_neuron(10), .resolution(8)) bus();
  activation_argmax #(.number_neuron(10), .resolution(8)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks = checks + 1;
    if (act !== expv) begin
      errors = errors + 1;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  function automatic logic [79:0] fill(input logic [7:0] x);
    logic [79:0] v;
    for (int i = 0; i < 10; i++) v[i*8 +: 8] = x;
    return v;
  endfunction

  function automatic logic [79:0] setl(input logic [79:0] v, input int i, input logic [7:0] x);
    logic [79:0] r;
    r = v;
    r[i*8 +: 8] = x;
    return r;
  endfunction

  // Monitor: latency on out_valid rise, result fields at the output handshake.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      prev_ov = 1'b0;
    end else begin
      if (bus.out_valid && !prev_ov) begin
        if (q.size() == 0) begin
          chk("unexpected_result", 32'(bus.out_valid), 32'd0);
        end else begin
          e = q[0];
          chk("latency", 32'(cyc - e.acc), 32'd9);
        end
      end
      if (bus.out_valid && bus.out_ready && q.size() > 0) begin
        e = q.pop_front();
        chk("digit", 32'(bus.digit), 32'(e.digit));
        chk("max_value", 32'(bus.max_value), 32'(e.maxv));
        chk("margin", 32'(bus.margin), 32'(e.margin));
        chk("low_confidence", 32'(bus.low_confidence), 32'(e.low));
      end
      prev_ov = bus.out_valid;
    end
  end

  task automatic send(input logic [79:0] v, input logic [7:0] thr, input bit expect_res,
                      input logic [3:0] ed, input logic [7:0] em, input logic [8:0] eg,
                      input logic el);
    int   n = 0;
    exp_t e;
    bus.activations = v;
    bus.threshold   = thr;
    bus.in_valid    = 1'b1;
    @(negedge clk);
    while (!bus.in_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (!bus.in_ready) begin
      chk("accept_timeout", 32'(bus.in_ready), 32'd1);
      bus.in_valid = 1'b0;
      return;
    end
    if (expect_res) begin
      e.digit = ed; e.maxv = em; e.margin = eg; e.low = el; e.acc = cyc + 1;
      q.push_back(e);
    end
    @(posedge clk); #1;
    bus.in_valid    = 1'b0;
    bus.activations = 80'({$urandom(), $urandom(), $urandom()});
    bus.threshold   = 8'($urandom());
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 300) begin
      n++;
      @(posedge clk); #1;
    end
    chk("drain_timeout", 32'(q.size()), 32'd0);
  endtask

  initial begin
    logic [79:0] v;
    logic [79:0] y;
    int n;
    bus.in_valid    = 1'b0;
    bus.activations = '0;
    bus.threshold   = '0;
    bus.out_ready   = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_digit", 32'(bus.digit), 32'd0);
    chk("rst_max_value", 32'(bus.max_value), 32'd0);
    chk("rst_margin", 32'(bus.margin), 32'd0);
    chk("rst_low", 32'(bus.low_confidence), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single clear winner
    send(setl(fill(8'd16), 7, 8'd100), 8'd20, 1'b1, 4'd7, 8'd100, 9'd84, 1'b0);
    drain();
    // Tie: lowest index wins, margin 0
    send(setl(setl(fill(8'hFB), 3, 8'd90), 8, 8'd90), 8'd1, 1'b1, 4'd3, 8'd90, 9'd0, 1'b1);
    drain();
    // All negative
    send(setl(setl(fill(8'hCE), 0, 8'h80), 5, 8'hFF), 8'd10, 1'b1, 4'd5, 8'hFF, 9'd49, 1'b0);
    drain();
    // Extremes, winner at the last lane then the first lane
    send(setl(fill(8'h80), 9, 8'h7F), 8'd255, 1'b1, 4'd9, 8'h7F, 9'd255, 1'b0);
    drain();
    send(setl(fill(8'h80), 0, 8'h7F), 8'd255, 1'b1, 4'd0, 8'h7F, 9'd255, 1'b0);
    drain();

    // Backpressure with a competing vector offered during DONE
    bus.out_ready = 1'b0;
    v = setl(setl(fill(8'd0), 4, 8'd60), 6, 8'd30);
    y = setl(fill(8'hEC), 1, 8'hF6);
    send(v, 8'd40, 1'b1, 4'd4, 8'd60, 9'd30, 1'b1);
    n = 0;
    while (!bus.out_valid && n < 50) begin
      n++;
      @(posedge clk); #1;
    end
    for (int i = 0; i < 5; i++) begin
      bus.in_valid    = 1'b1;
      bus.activations = y;
      bus.threshold   = 8'd5;
      chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
      chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
      chk("bp_digit", 32'(bus.digit), 32'd4);
      chk("bp_max_value", 32'(bus.max_value), 32'd60);
      chk("bp_margin", 32'(bus.margin), 32'd30);
      @(posedge clk); #1;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_out_valid", 32'(bus.out_valid), 32'd0);
    chk("bp_release_in_ready", 32'(bus.in_ready), 32'd1);
    chk("bp_queue_empty", 32'(q.size()), 32'd0);
    send(y, 8'd5, 1'b1, 4'd1, 8'hF6, 9'd10, 1'b0);
    drain();

    // Reset while scanning lane 4: result must be dropped
    send(setl(fill(8'd0), 9, 8'd77), 8'd0, 1'b0, 4'd0, 8'd0, 9'd0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_digit", 32'(bus.digit), 32'd0);
    chk("mid_rst_max_value", 32'(bus.max_value), 32'd0);
    chk("mid_rst_margin", 32'(bus.margin), 32'd0);
    chk("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("mid_rst_busy", 32'(bus.busy), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    chk("post_rst_out_valid", 32'(bus.out_valid), 32'd0);
    send(setl(fill(8'd0), 2, 8'd50), 8'd0, 1'b1, 4'd2, 8'd50, 9'd50, 1'b0);
    drain();

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/activation_argmax.md
# activation_argmax

Sequential classifier stage that consumes the flattened signed activation vector of the output layer and resolves the recognised digit. It captures one vector per valid/ready handshake and scans one lane per clock. It then reports the winning neuron index, its activation, and the margin over the runner-up. A low-confidence flag is raised against a programmable threshold. It sits after the output-layer sigmoid bank and feeds the display/readout logic.

## Interface
- number_neuron, 10, lanes in the activation vector; must be ≥ 2
- resolution, 8, bits per lane, two's-complement signed
- IDX_W (localparam), $clog2(number_neuron), width of digit
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  activations/threshold valid
- in_ready  out  1  block accepts a vector; equals (state == IDLE)
- activations  in  resolution*number_neuron  lane i at bits [(i+1)*resolution-1 -: resolution], signed
- threshold  in  resolution  unsigned margin threshold, sampled with activations
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- digit  out  IDX_W  index of the maximum lane
- max_value  out  resolution  signed activation of the winning lane
- margin  out  resolution+1  unsigned, max_value minus runner-up value
- low_confidence  out  1  margin < threshold
- busy  out  1  state is SCAN or DONE

## Operation
- States: IDLE, SCAN, DONE.
- IDLE: in_ready=1.
  - On in_valid, register the whole vector and threshold.
  - Initialise best=lane0, best_idx=0, second=-2^(resolution-1), k=1.
  - Go to SCAN.
  - Inputs may change after the accept edge.
- SCAN, one lane k per cycle:
  - If lane_k > best (signed, strict): second←best, best←lane_k, best_idx←k.
  - Else if lane_k > second: second←lane_k.
  - k increments.
  - The edge that processes k=number_neuron-1 loads the result registers and moves to DONE.
- Tie rule: on equal maxima the lowest index wins, and the equal value becomes the runner-up, giving margin=0.
- Arithmetic:
  - margin = best − second, computed in resolution+1 bits signed; it is always ≥ 0 and is output as unsigned.
  - low_confidence = margin < {1'b0, threshold}, unsigned compare.
- DONE:
  - out_valid=1.
  - All result outputs are held stable until out_ready=1.
  - The handshake edge returns to IDLE and clears out_valid.
- in_valid outside IDLE is ignored; there is no queueing.
- out_ready outside DONE is ignored.

## Timing
- Reset (rst_n=0, asynchronous):
  - state=IDLE, out_valid=0, digit=0, max_value=0, margin=0, low_confidence=0, busy=0, k=0.
  - in_ready=1 once in IDLE.
- Latency: out_valid rises number_neuron−1 cycles after the accept edge (9 for the default).
- Results register on the same edge that out_valid rises; there are no combinational input-to-output paths except in_ready/busy from state.
- Minimum initiation interval is number_neuron+1 cycles with out_ready tied high. The next accept can occur on the cycle after the DONE handshake.
- Reset mid-SCAN or mid-DONE:
  - The result is discarded and out_valid drops immediately.
  - No partial result is ever presented.
- Result outputs retain their last value after the handshake until the next DONE load.

## Test plan
- Lanes all 16 except lane7=100, threshold=20 -> digit=7, max_value=100, margin=84, low_confidence=0, out_valid exactly 9 cycles after accept.
- Lanes 3 and 8 =90, others −5, threshold=1 -> digit=3, max_value=90, margin=0, low_confidence=1.
- All negative: lane0=−128, lane5=−1, others −50 -> digit=5, max_value=8'hFF, margin=49.
- Extremes: lane9=127, others −128, threshold=255 -> digit=9, margin=255, low_confidence=0. Repeat with lane0=127 -> digit=0.
- Backpressure: hold out_ready=0 for 5 cycles in DONE while pulsing in_valid with a new vector:
  - Outputs stay stable, in_ready=0, and the new vector is not captured.
  - After out_ready=1, out_valid=0 and in_ready=1 next cycle; the next vector yields its own correct result.
- Assert rst_n=0 for one cycle at SCAN k=4:
  - out_valid stays 0, outputs read 0, in_ready=1.
  - The subsequent vector (lane2=50, others 0) -> digit=2, margin=50.
